// File: rtl/reg_rotate_ctrl_if.sv
// rtl/reg_rotate_ctrl_if.sv - command port bundle for the register rotate sequencer
interface reg_rotate_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_cnt,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_cnt,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/reg_rotate_ctrl.sv
// rtl/reg_rotate_ctrl.sv - three-register load/swap/clear/rotate sequencer
// One register-transfer step per clock; all destinations take pre-edge source values.
module reg_rotate_ctrl #(
  parameter int               WIDTH  = 32,
  parameter int               CNT_W  = 4,
  parameter logic [WIDTH-1:0] A_INIT = WIDTH'(1),
  parameter logic [WIDTH-1:0] B_INIT = WIDTH'(0),
  parameter logic [WIDTH-1:0] C_INIT = WIDTH'(1)
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_rotate_ctrl_if.slave   cmd,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD_A  = 3'd1,
    OP_LOAD_B  = 3'd2,
    OP_LOAD_C  = 3'd3,
    OP_ROT_L   = 3'd4,
    OP_ROT_R   = 3'd5,
    OP_SWAP_AC = 3'd6,
    OP_CLEAR   = 3'd7
  } op_t;

  state_t           state;
  state_t           state_nxt;
  op_t              op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic             accept;
  logic             step;
  logic             is_rot;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic [WIDTH-1:0] c_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A zero remaining count still spends one EXEC cycle, just without a transfer.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        step = (rem_q != '0);
        if (rem_q <= CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign cmd.cmd_ready = rst_n && (state == ST_IDLE);
  assign busy          = (state == ST_EXEC) || (state == ST_DONE);
  assign done          = (state == ST_DONE);

  assign is_rot = (cmd.cmd_op == OP_ROT_L) || (cmd.cmd_op == OP_ROT_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_NOP;
      data_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      op_q   <= op_t'(cmd.cmd_op);
      data_q <= cmd.cmd_data;
      rem_q  <= is_rot ? cmd.cmd_cnt : CNT_W'(1);
    end else if (step) begin
      rem_q  <= rem_q - CNT_W'(1);
    end
  end

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    c_nxt = c;
    case (op_q)
      OP_LOAD_A:  a_nxt = data_q;
      OP_LOAD_B:  b_nxt = data_q;
      OP_LOAD_C:  c_nxt = data_q;
      OP_ROT_L: begin
        a_nxt = b;
        b_nxt = c;
        c_nxt = a;
      end
      OP_ROT_R: begin
        a_nxt = c;
        b_nxt = a;
        c_nxt = b;
      end
      OP_SWAP_AC: begin
        a_nxt = c;
        c_nxt = a;
      end
      OP_CLEAR: begin
        a_nxt = '0;
        b_nxt = '0;
        c_nxt = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= A_INIT;
      b <= B_INIT;
      c <= C_INIT;
    end else if (step) begin
      a <= a_nxt;
      b <= b_nxt;
      c <= c_nxt;
    end
  end

endmodule

// File: doc/reg_rotate_ctrl.md
# reg_rotate_ctrl

Command-driven sequencer for a bank of three WIDTH-bit registers (a, b, c). It applies load, swap, clear and repeated-rotate transfers, one register-transfer step per clock. All three registers update simultaneously on each step: every destination takes the pre-edge value of its source. A valid/ready command port accepts one command at a time, `busy` is high while a command executes, and `done` pulses for one cycle when it finishes.

## Interface
- WIDTH, 32, register and data width
- CNT_W, 4, width of the rotate repeat count
- A_INIT, 1, reset value of a
- B_INIT, 0, reset value of b
- C_INIT, 1, reset value of c

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  opcode, sampled on the accept edge
- cmd_cnt  in  CNT_W  repeat count for ROT_L/ROT_R, sampled on the accept edge
- cmd_data  in  WIDTH  load value, sampled on the accept edge
- a, b, c  out  WIDTH each  register outputs
- busy  out  1  command executing (EXEC or DONE state)
- done  out  1  one-cycle completion pulse

## Operation
- Opcodes:
  - 0 NOP: no change.
  - 1 LOAD_A: a←data.
  - 2 LOAD_B: b←data.
  - 3 LOAD_C: c←data.
  - 4 ROT_L: a←b, b←c, c←a.
  - 5 ROT_R: a←c, b←a, c←b.
  - 6 SWAP_AC: a↔c, b unchanged.
  - 7 CLEAR: a, b, c←0.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: cmd_ready=1. When cmd_valid=1, latch op, data and remaining step count, then go to EXEC.
  - EXEC: one step per cycle. A step applies the op's transfer and decrements remaining. When remaining reaches 1, the final step is applied and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Step count:
  - ROT_L/ROT_R: cmd_cnt steps. Rotations run literally, with no mod-3 reduction; intermediate values are visible on a/b/c.
  - ROT_L/ROT_R with cmd_cnt=0: one EXEC cycle with no transfer, so it behaves as NOP.
  - All other ops: exactly one step.
- Ignored inputs:
  - cmd_valid while cmd_ready=0 is ignored; no queuing, no error.
  - cmd_op/cmd_cnt/cmd_data are don't-care except on the accept edge.
  - Latched values are immune to input changes during EXEC.
- Width: all transfers are full-WIDTH copies, with no arithmetic.
- Reset (rst_n=0), asynchronous:
  - a=A_INIT, b=B_INIT, c=C_INIT.
  - State IDLE, remaining=0.
  - busy=0, done=0, cmd_ready=0 while rst_n is low; cmd_ready=1 from the first cycle after release.
  - Reset mid-EXEC abandons the command. No done pulse is issued, and partial rotations are discarded because registers return to their init values.

## Timing
- Accept edge k (IDLE, cmd_valid=1):
  - busy=1 and cmd_ready=0 from cycle k+1.
  - Step i (i=1..n) takes effect at edge k+i.
  - done=1 during the cycle after edge k+n.
  - At edge k+n+1, the FSM is in IDLE with cmd_ready=1, busy=0 and done=0.
- Single-step ops: registers change at k+1, done after k+1, ready again after k+2.
- Throughput: back-to-back commands are accepted every n+2 cycles.
- done and the final register values are coincident: when done=1, a/b/c already hold the final values.
- Outputs are registered, with no combinational path from cmd_* to a/b/c/done.
- cmd_ready is a decode of state only and does not depend on cmd_valid.

## Test plan
- Reset and release:
  - During reset: a=1, b=0, c=1, busy=0, done=0, cmd_ready=0.
  - After release: cmd_ready=1.
- Loads and rotate:
  - Send LOAD_A 0x11, LOAD_B 0x22, LOAD_C 0x33 back-to-back with cmd_valid held high: each is accepted 3 cycles apart.
  - Then ROT_L cnt=1, accepted at edge k: at k+1, (a,b,c)=(0x22,0x33,0x11); done high in cycle k+1..k+2; cmd_ready high after k+2.
- ROT_R cnt=3 from (0x22,0x33,0x11):
  - Intermediate values (0x11,0x22,0x33) at k+1, then (0x33,0x11,0x22) at k+2.
  - Final (0x22,0x33,0x11) at k+3; done after k+3.
  - cnt=0 variant: no change, done after k+1.
- SWAP_AC then CLEAR:
  - From (0x22,0x33,0x11), SWAP_AC gives (0x11,0x33,0x22).
  - CLEAR gives (0,0,0). done pulses exactly once per command.
- Busy-period stimulus:
  - During ROT_L cnt=5, pulse cmd_valid with LOAD_A 0xDEADBEEF every cycle.
  - Rotation completes unchanged and 0xDEADBEEF never appears on a.
  - The first accept occurs only in IDLE, after done.
- Async reset at edge k+2 of ROT_L cnt=5:
  - Immediately (not at a clock edge): a/b/c=1/0/1 and busy=0.
  - No done pulse occurs.
  - The next command executes normally from the init values.
